// File: rtl/pipe_sched_if.sv
// Pipeline hazard/scheduler bundle: stage inputs from the datapath, stage controls back out.
// Pure wiring; no latency of its own.
// No backpressure: the scheduler's outputs are the backpressure for the pipeline.
interface pipe_sched_if;
  // Hazard-detection inputs from the pipeline stages
  logic        EX_MemRead;
  logic [4:0]  EX_rt;
  logic [4:0]  ID_rs;
  logic [4:0]  ID_rt;
  logic        MEM_Branch_taken;
  logic        MEM_MemRead;
  logic        MEM_MemWrite;
  logic        dmem_ack;

  // Stage-register controls and status
  logic        dmem_req;
  logic        pc_we;
  logic        IF_ID_we;
  logic        EX_MEM_we;
  logic        IF_ID_flush;
  logic        ID_EX_flush;
  logic        EX_MEM_flush;
  logic        ID_EX_bubble;
  logic        MEM_WB_bubble;
  logic [15:0] stall_cnt;
  logic [15:0] flush_cnt;
  logic        mem_err;

  // Pipeline datapath side: drives hazard inputs, consumes controls
  modport master (
    output EX_MemRead, EX_rt, ID_rs, ID_rt, MEM_Branch_taken,
           MEM_MemRead, MEM_MemWrite, dmem_ack,
    input  dmem_req, pc_we, IF_ID_we, EX_MEM_we, IF_ID_flush, ID_EX_flush,
           EX_MEM_flush, ID_EX_bubble, MEM_WB_bubble, stall_cnt, flush_cnt, mem_err
  );

  // Scheduler side
  modport slave (
    input  EX_MemRead, EX_rt, ID_rs, ID_rt, MEM_Branch_taken,
           MEM_MemRead, MEM_MemWrite, dmem_ack,
    output dmem_req, pc_we, IF_ID_we, EX_MEM_we, IF_ID_flush, ID_EX_flush,
           EX_MEM_flush, ID_EX_bubble, MEM_WB_bubble, stall_cnt, flush_cnt, mem_err
  );
endinterface

// File: rtl/pipe_sched.sv
// Pipeline scheduler: memory-wait freeze, branch flush and load-use stall control.
// Stage controls are combinational (zero-cycle); counters/flags update on the next edge.
// A pending data-memory access freezes the whole pipeline until ack or a 255-cycle timeout.
module pipe_sched (
  input  logic         clk,
  input  logic         reset,
  pipe_sched_if.slave  bus
);

  typedef enum logic [0:0] {
    RUN      = 1'b0,
    MEM_WAIT = 1'b1
  } state_t;

  localparam logic [7:0]  WAIT_LIMIT = 8'hFF;
  localparam logic [15:0] CNT_MAX    = 16'hFFFF;

  state_t      state_q, state_d;
  logic [7:0]  wait_q, wait_d;
  logic [15:0] stall_cnt_q, stall_cnt_d;
  logic [15:0] flush_cnt_q, flush_cnt_d;
  logic        mem_err_q, mem_err_d;

  logic mem_access;
  logic timeout;
  logic freeze;
  logic flush;
  logic hazard;
  logic load_use;

  // Event classification with priority freeze > flush > load-use
  always_comb begin
    mem_access = bus.MEM_MemRead | bus.MEM_MemWrite;
    // The counter only leaves zero while waiting, so hitting the limit means
    // 255 freeze cycles have already elapsed; this cycle is treated as an ack.
    timeout    = (state_q == MEM_WAIT) && (wait_q == WAIT_LIMIT) && !bus.dmem_ack;
    freeze     = mem_access && !bus.dmem_ack && !timeout;
    flush      = !freeze && bus.MEM_Branch_taken;
    // $0 is hardwired zero, so a load into it never creates a dependency
    hazard     = bus.EX_MemRead && (bus.EX_rt != 5'd0) &&
                 ((bus.EX_rt == bus.ID_rs) || (bus.EX_rt == bus.ID_rt));
    load_use   = !freeze && !flush && hazard;
  end

  // Next-state: wait tracking, sticky timeout flag, saturating event counters
  always_comb begin
    state_d     = RUN;
    wait_d      = 8'd0;
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    mem_err_d   = mem_err_q | timeout;

    if (freeze) begin
      state_d = MEM_WAIT;
      wait_d  = wait_q + 8'd1;
    end

    if (flush && (flush_cnt_q != CNT_MAX)) begin
      flush_cnt_d = flush_cnt_q + 16'd1;
    end

    if (load_use && (stall_cnt_q != CNT_MAX)) begin
      stall_cnt_d = stall_cnt_q + 16'd1;
    end
  end

  // FSM and counter state; reset aborts any outstanding wait
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= RUN;
      wait_q      <= 8'd0;
      stall_cnt_q <= 16'd0;
      flush_cnt_q <= 16'd0;
      mem_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      wait_q      <= wait_d;
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
      mem_err_q   <= mem_err_d;
    end
  end

  // Stage controls; reset forces every stage register to hold a NOP
  always_comb begin
    bus.dmem_req      = 1'b0;
    bus.pc_we         = 1'b0;
    bus.IF_ID_we      = 1'b0;
    bus.EX_MEM_we     = 1'b0;
    bus.IF_ID_flush   = 1'b1;
    bus.ID_EX_flush   = 1'b1;
    bus.EX_MEM_flush  = 1'b1;
    bus.ID_EX_bubble  = 1'b1;
    bus.MEM_WB_bubble = 1'b1;

    if (!reset) begin
      bus.dmem_req      = mem_access;
      bus.IF_ID_flush   = 1'b0;
      bus.ID_EX_flush   = 1'b0;
      bus.EX_MEM_flush  = 1'b0;
      bus.ID_EX_bubble  = 1'b0;
      bus.MEM_WB_bubble = 1'b0;
      if (freeze) begin
        // Everything holds; MEM/WB takes a bubble so WB does not repeat
        bus.MEM_WB_bubble = 1'b1;
      end else if (flush) begin
        // PC mux already points at the target; squash the three younger stages
        bus.pc_we        = 1'b1;
        bus.IF_ID_we     = 1'b1;
        bus.EX_MEM_we    = 1'b1;
        bus.IF_ID_flush  = 1'b1;
        bus.ID_EX_flush  = 1'b1;
        bus.EX_MEM_flush = 1'b1;
      end else if (load_use) begin
        // Hold IF/ID, let the load move on; one cycle is always enough
        bus.EX_MEM_we    = 1'b1;
        bus.ID_EX_bubble = 1'b1;
      end else begin
        bus.pc_we     = 1'b1;
        bus.IF_ID_we  = 1'b1;
        bus.EX_MEM_we = 1'b1;
      end
    end
  end

  assign bus.stall_cnt = stall_cnt_q;
  assign bus.flush_cnt = flush_cnt_q;
  assign bus.mem_err   = mem_err_q;

endmodule

// File: tb/tb_pipe_sched.sv
// Directed bench for pipe_sched: reset, load-use, $0, memory wait, priority,
// timeout, counter saturation and reset during a wait.
module tb_pipe_sched;

  logic clk = 1'b0;
  logic reset = 1'b0;
  int   tests = 0;
  int   fails = 0;

  pipe_sched_if bus ();

  pipe_sched dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  // {pc_we, IF_ID_we, EX_MEM_we, IF_ID_flush, ID_EX_flush, EX_MEM_flush,
  //  ID_EX_bubble, MEM_WB_bubble, dmem_req}
  localparam logic [8:0] C_RST    = 9'b000_111_11_0;
  localparam logic [8:0] C_IDLE   = 9'b111_000_00_0;
  localparam logic [8:0] C_STALL  = 9'b001_000_10_0;
  localparam logic [8:0] C_FREEZE = 9'b000_000_01_1;
  localparam logic [8:0] C_ACK    = 9'b111_000_00_1;
  localparam logic [8:0] C_FLUSH  = 9'b111_111_00_0;

  function automatic logic [15:0] ctl();
    return {7'd0, bus.pc_we, bus.IF_ID_we, bus.EX_MEM_we,
            bus.IF_ID_flush, bus.ID_EX_flush, bus.EX_MEM_flush,
            bus.ID_EX_bubble, bus.MEM_WB_bubble, bus.dmem_req};
  endfunction

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    bus.EX_MemRead       = 1'b0;
    bus.EX_rt            = 5'd0;
    bus.ID_rs            = 5'd0;
    bus.ID_rt            = 5'd0;
    bus.MEM_Branch_taken = 1'b0;
    bus.MEM_MemRead      = 1'b0;
    bus.MEM_MemWrite     = 1'b0;
    bus.dmem_ack         = 1'b0;
  endtask

  initial begin
    int n;
    // Reset with every event input active: outputs must still show the reset pattern
    reset = 1'b1;
    bus.EX_MemRead = 1'b1; bus.EX_rt = 5'd5; bus.ID_rs = 5'd5; bus.ID_rt = 5'd0;
    bus.MEM_Branch_taken = 1'b1; bus.MEM_MemRead = 1'b1; bus.MEM_MemWrite = 1'b0;
    bus.dmem_ack = 1'b0;
    #1;
    chk("rst_ctl", ctl(), {7'd0, C_RST});
    tick(); tick();
    chk("rst_ctl_hold", ctl(), {7'd0, C_RST});
    chk("rst_stall_cnt", bus.stall_cnt, 16'd0);
    chk("rst_flush_cnt", bus.flush_cnt, 16'd0);
    chk("rst_mem_err", {15'd0, bus.mem_err}, 16'd0);
    clear_inputs();
    reset = 1'b0;
    #1;
    chk("idle_ctl", ctl(), {7'd0, C_IDLE});
    tick();

    // Load-use via ID_rs
    bus.EX_MemRead = 1'b1; bus.EX_rt = 5'd5; bus.ID_rs = 5'd5; bus.ID_rt = 5'd9;
    #1;
    chk("lu_rs_ctl", ctl(), {7'd0, C_STALL});
    chk("lu_rs_cnt_before", bus.stall_cnt, 16'd0);
    tick();
    clear_inputs();
    #1;
    chk("lu_rs_cnt_after", bus.stall_cnt, 16'd1);
    chk("lu_rs_release", ctl(), {7'd0, C_IDLE});
    tick();

    // Load-use via ID_rt
    bus.EX_MemRead = 1'b1; bus.EX_rt = 5'd7; bus.ID_rs = 5'd3; bus.ID_rt = 5'd7;
    #1;
    chk("lu_rt_ctl", ctl(), {7'd0, C_STALL});
    tick();
    clear_inputs();
    #1;
    chk("lu_rt_cnt", bus.stall_cnt, 16'd2);

    // $0 never stalls
    bus.EX_MemRead = 1'b1; bus.EX_rt = 5'd0; bus.ID_rs = 5'd0; bus.ID_rt = 5'd0;
    #1;
    chk("r0_ctl", ctl(), {7'd0, C_IDLE});
    tick();
    clear_inputs();
    #1;
    chk("r0_cnt", bus.stall_cnt, 16'd2);

    // Memory wait: 3 freeze cycles then ack; branch+hazard during freeze not counted
    bus.MEM_MemRead = 1'b1; bus.dmem_ack = 1'b0;
    for (int i = 0; i < 3; i++) begin
      if (i == 1) begin
        bus.MEM_Branch_taken = 1'b1;
        bus.EX_MemRead = 1'b1; bus.EX_rt = 5'd4; bus.ID_rs = 5'd4;
      end else begin
        bus.MEM_Branch_taken = 1'b0;
        bus.EX_MemRead = 1'b0;
      end
      #1;
      chk("mw_freeze", ctl(), {7'd0, C_FREEZE});
      tick();
    end
    bus.MEM_Branch_taken = 1'b0; bus.EX_MemRead = 1'b0;
    chk("mw_no_flush_cnt", bus.flush_cnt, 16'd0);
    chk("mw_no_stall_cnt", bus.stall_cnt, 16'd2);
    bus.dmem_ack = 1'b1;
    #1;
    chk("mw_ack", ctl(), {7'd0, C_ACK});
    tick();
    clear_inputs();
    #1;
    chk("mw_after", ctl(), {7'd0, C_IDLE});
    tick();

    // Priority: flush beats load-use
    bus.MEM_Branch_taken = 1'b1;
    bus.EX_MemRead = 1'b1; bus.EX_rt = 5'd12; bus.ID_rs = 5'd1; bus.ID_rt = 5'd12;
    #1;
    chk("prio_ctl", ctl(), {7'd0, C_FLUSH});
    tick();
    clear_inputs();
    #1;
    chk("prio_flush_cnt", bus.flush_cnt, 16'd1);
    chk("prio_stall_cnt", bus.stall_cnt, 16'd2);
    tick();

    // Timeout: 255 freeze cycles, then the pipeline advances and mem_err sets
    bus.MEM_MemWrite = 1'b1; bus.dmem_ack = 1'b0;
    for (int i = 0; i < 255; i++) begin
      #1;
      chk("tmo_freeze", ctl(), {7'd0, C_FREEZE});
      tick();
    end
    #1;
    chk("tmo_advance", ctl(), {7'd0, C_ACK});
    chk("tmo_err_before", {15'd0, bus.mem_err}, 16'd0);
    tick();
    clear_inputs();
    #1;
    chk("tmo_err_set", {15'd0, bus.mem_err}, 16'd1);
    chk("tmo_idle", ctl(), {7'd0, C_IDLE});
    tick(); tick(); tick();
    chk("tmo_err_sticky", {15'd0, bus.mem_err}, 16'd1);

    // Saturation: 2 stalls so far, 65533 more reach FFFF, one extra holds it
    bus.EX_MemRead = 1'b1; bus.EX_rt = 5'd31; bus.ID_rs = 5'd31;
    repeat (65533) tick();
    chk("sat_reach", bus.stall_cnt, 16'hFFFF);
    chk("sat_ctl", ctl(), {7'd0, C_STALL});
    tick();
    chk("sat_hold", bus.stall_cnt, 16'hFFFF);
    clear_inputs();
    tick();

    // Reset in the middle of a memory wait
    bus.MEM_MemRead = 1'b1; bus.dmem_ack = 1'b0;
    tick(); tick();
    #2;
    reset = 1'b1;
    #1;
    chk("rstw_ctl", ctl(), {7'd0, C_RST});
    chk("rstw_stall_cnt", bus.stall_cnt, 16'd0);
    chk("rstw_flush_cnt", bus.flush_cnt, 16'd0);
    chk("rstw_mem_err", {15'd0, bus.mem_err}, 16'd0);
    tick();
    bus.MEM_MemRead = 1'b0;
    reset = 1'b0;
    #1;
    chk("rstw_idle", ctl(), {7'd0, C_IDLE});
    tick();

    // Fresh wait after reset must again allow exactly 255 freeze cycles
    bus.MEM_MemRead = 1'b1; bus.dmem_ack = 1'b0;
    n = 0;
    #1;
    while (ctl() == {7'd0, C_FREEZE} && n < 300) begin
      n++;
      tick();
      #1;
    end
    chk("rstw_fresh_wait", n[15:0], 16'd255);
    clear_inputs();
    tick();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/pipe_sched.md
PIPE_SCHED -- requirements
Module: pipe_sched

Interface
REQ-001 The block SHALL use one clock and an asynchronous, active-high reset; ports SHALL be exactly as listed below (name  direction  width  meaning).
REQ-002 clk  in  1  pipeline clock; all state updates on rising edge.
REQ-003 reset  in  1  asynchronous, active-high reset.
REQ-004 EX_MemRead  in  1  EX-stage instruction is a load.
REQ-005 EX_rt  in  5  load destination register in EX.
REQ-006 ID_rs, ID_rt  in  5 each  source registers of the ID-stage instruction.
REQ-007 MEM_Branch_taken  in  1  branch resolved taken in MEM; the PC mux already selects the target.
REQ-008 MEM_MemRead, MEM_MemWrite  in  1 each  MEM-stage data-memory access.
REQ-009 dmem_ack  in  1  data memory completes the current access this cycle.
REQ-010 dmem_req  out  1  data-memory access request.
REQ-011 pc_we, IF_ID_we, EX_MEM_we  out  1 each  stage register write enables.
REQ-012 IF_ID_flush, ID_EX_flush, EX_MEM_flush  out  1 each  load NOP into the stage register.
REQ-013 ID_EX_bubble, MEM_WB_bubble  out  1 each  zero control fields entering ID/EX and MEM/WB.
REQ-014 stall_cnt, flush_cnt  out  16 each  load-use stall and branch flush event counters.
REQ-015 mem_err  out  1  sticky data-memory timeout flag.

Function
REQ-016 The FSM SHALL have two states: RUN and MEM_WAIT. Stage-control outputs SHALL be combinational from state and inputs, with zero-cycle latency.
REQ-017 mem_access = MEM_MemRead | MEM_MemWrite; dmem_req SHALL equal mem_access whenever reset is low.
REQ-018 A freeze occurs when mem_access=1 and dmem_ack=0. During a freeze: pc_we=IF_ID_we=EX_MEM_we=0, MEM_WB_bubble=1, all flushes=0, ID_EX_bubble=0, and the next state is MEM_WAIT.
REQ-019 In MEM_WAIT, an 8-bit wait counter SHALL increment every cycle. When dmem_ack=1, the block SHALL return to RUN, clear the counter, and not freeze in that cycle.
REQ-020 If the wait counter reaches 255 without dmem_ack, the block SHALL set mem_err (sticky until reset), return to RUN, clear the counter, and treat that cycle as an ack.
REQ-021 A flush occurs when there is no freeze and MEM_Branch_taken=1. All three flushes SHALL be 1, pc_we=IF_ID_we=EX_MEM_we=1, ID_EX_bubble=0, and flush_cnt SHALL increment.
REQ-022 A load-use stall occurs when there is no freeze, no flush, EX_MemRead=1, EX_rt!=0, and (EX_rt==ID_rs or EX_rt==ID_rt).
REQ-023 During a load-use stall: pc_we=IF_ID_we=0, ID_EX_bubble=1, EX_MEM_we=1, and stall_cnt SHALL increment.
REQ-024 Priority SHALL be freeze > flush > load-use. A suppressed lower-priority event SHALL NOT be counted in that cycle; it is re-evaluated on the next cycle.
REQ-025 With no event: all we=1, all flush/bubble=0.
REQ-026 Both counters SHALL saturate at 16'hFFFF; they SHALL NOT wrap.
REQ-027 A load-use stall on any instruction SHALL last exactly one cycle, because the load advances to MEM on the next edge.

Reset
REQ-028 While reset=1: state=RUN, wait counter=0, stall_cnt=flush_cnt=0, mem_err=0.
REQ-029 While reset=1, all we outputs=0, all flush/bubble outputs=1, and dmem_req=0, regardless of other inputs.
REQ-030 Reset asserted during MEM_WAIT SHALL abort the wait immediately. After release the block SHALL be in RUN with no pending access remembered.

Verification
REQ-031 Load-use: EX_MemRead=1, EX_rt=5, ID_rs=5 for one cycle -> pc_we=0, IF_ID_we=0, ID_EX_bubble=1; stall_cnt 0->1.
REQ-032 $0 exclusion: EX_MemRead=1, EX_rt=0, ID_rt=0 -> no stall; all we=1, stall_cnt unchanged.
REQ-033 Memory wait: MEM_MemRead=1, dmem_ack low for 3 cycles then high -> 3 freeze cycles (pc_we=0, MEM_WB_bubble=1), dmem_req=1 for 4 cycles; on the ack cycle all we=1 and the state returns to RUN.
REQ-034 Priority: in the same cycle MEM_Branch_taken=1 and a load-use hazard present, with no mem access -> flushes=1, ID_EX_bubble=0; flush_cnt +1, stall_cnt +0.
REQ-035 Timeout: MEM_MemWrite=1, dmem_ack held 0 -> freeze for 255 cycles, then mem_err=1 and the pipeline advances; mem_err stays 1 until reset.
REQ-036 Saturation/reset: preload stall_cnt to 16'hFFFF via repeated hazards, apply one more -> remains FFFF; assert reset mid-MEM_WAIT -> counters 0, state RUN, outputs match REQ-029.
